// File: rtl/minimig_autoconfig_sequencer_pkg.sv
// Shared types and constants for the autoconfig sequencer.
package minimig_autoconfig_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_TYPE,
    S_RD_SIZE,
    S_DECODE,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  // Autoconfig register offsets (byte offsets, A8:0)
  localparam logic [8:0] AC_TYPE   = 9'h000;
  localparam logic [8:0] AC_SIZE   = 9'h002;
  localparam logic [8:0] AC_Z3BASE = 9'h044;
  localparam logic [8:0] AC_Z2BASE = 9'h048;
  localparam logic [8:0] AC_SHUTUP = 9'h04C;

  // Board type codes from nibble[3:2] of offset 0x00
  localparam logic [1:0] TYPE_Z2 = 2'b11;
  localparam logic [1:0] TYPE_Z3 = 2'b10;

  // The bus carries A8:1, so drop the byte bit of an offset
  function automatic logic [7:0] word_addr(input logic [8:0] off);
    return off[8:1];
  endfunction

endpackage

// File: rtl/minimig_ac_size_decode.sv
// Board size decode and base placement. Pointers and limits are in 64K
// units (A23:16 for Zorro II, A31:16 for Zorro III); each path carries one
// extra carry bit so a wrap past the top of the space never looks like a fit.
module minimig_ac_size_decode (
  input  logic        is_z3,
  input  logic [2:0]  code,
  input  logic [15:0] pointer,
  input  logic [15:0] limit,
  output logic [15:0] base,
  output logic [15:0] next_ptr,
  output logic        fits
);

  logic [8:0]  z2_size, z2_mask, z2_base, z2_end;
  logic        z2_fits;
  logic [16:0] z3_size, z3_mask, z3_base, z3_end;
  logic        z3_fits;

  // Zorro II: 8M for code 0, otherwise 64K << (code-1). Alignment is capped
  // at 2M, so an 8M board still lands at 0x200000 and fills the space.
  always_comb begin
    z2_size = (code == 3'd0) ? 9'h080 : (9'h001 << (code - 3'd1));
    z2_mask = (code == 3'd0 || code >= 3'd6) ? 9'h01F : (z2_size - 9'h001);
    z2_base = ({1'b0, pointer[7:0]} + z2_mask) & ~z2_mask;
    z2_end  = z2_base + z2_size;
    z2_fits = (z2_end <= {1'b0, limit[7:0]});
  end

  // Zorro III: 16M << code for codes 0..3, codes 4..7 are never placed
  always_comb begin
    z3_size = 17'h00100 << code[1:0];
    z3_mask = z3_size - 17'h00001;
    z3_base = ({1'b0, pointer} + z3_mask) & ~z3_mask;
    z3_end  = z3_base + z3_size;
    z3_fits = !code[2] && (z3_end <= {1'b0, limit});
  end

  // Select the path for the board type being configured
  always_comb begin
    if (is_z3) begin
      base     = z3_base[15:0];
      next_ptr = z3_end[15:0];
      fits     = z3_fits;
    end else begin
      base     = {8'h00, z2_base[7:0]};
      next_ptr = {8'h00, z2_end[7:0]};
      fits     = z2_fits;
    end
  end

endmodule

// File: rtl/minimig_autoconfig_sequencer.sv
// Hardware autoconfig master. Passes CPU cycles to the autoconfig slave when
// idle; after a start pulse it stalls the CPU, walks the board chain, places
// each board in Zorro II/III space and shuts up boards that do not fit.
module minimig_autoconfig_sequencer
  import minimig_autoconfig_pkg::*;
#(
  parameter logic [7:0]  Z2_START   = 8'h20,
  parameter logic [7:0]  Z2_LIMIT   = 8'hA0,
  parameter logic [15:0] Z3_START   = 16'h4000,
  parameter logic [15:0] Z3_LIMIT   = 16'h8000,
  parameter int          MAX_BOARDS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        start,
  input  logic [7:0]  cpu_address,
  input  logic [15:0] cpu_data,
  input  logic        cpu_rd,
  input  logic        cpu_hwr,
  input  logic        cpu_lwr,
  input  logic        cpu_sel,
  output logic        cpu_wait,
  output logic [7:0]  ac_address,
  output logic [15:0] ac_wdata,
  output logic        ac_rd,
  output logic        ac_hwr,
  output logic        ac_lwr,
  output logic        ac_sel,
  input  logic [15:0] ac_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  board_count,
  output logic [7:0]  z2_next,
  output logic [15:0] z3_next
);

  localparam logic [2:0] LAST_BOARD = 3'(MAX_BOARDS - 1);

  state_t      state, state_nx;
  logic        second;       // second beat of a two-beat read
  logic        start_pend;
  logic        is_z3;
  logic [2:0]  code;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        go;
  logic        type_ok;
  logic [15:0] dec_ptr, dec_limit, dec_base, dec_next;
  logic        dec_fits;
  logic [11:0] unused_rdata;

  assign unused_rdata = ac_rdata[11:0];
  assign go           = start | start_pend;
  assign type_ok      = (ac_rdata[15:14] == TYPE_Z2) || (ac_rdata[15:14] == TYPE_Z3);
  assign dec_ptr      = is_z3 ? z3_next : {8'h00, z2_next};
  assign dec_limit    = is_z3 ? Z3_LIMIT : {8'h00, Z2_LIMIT};

  minimig_ac_size_decode u_size (
    .is_z3    (is_z3),
    .code     (code),
    .pointer  (dec_ptr),
    .limit    (dec_limit),
    .base     (dec_base),
    .next_ptr (dec_next),
    .fits     (dec_fits)
  );

  // State register, advances only on bus beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        state <= S_IDLE;
    else if (clk7_en) state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (go) state_nx = S_RD_TYPE;
      S_RD_TYPE: if (second) state_nx = type_ok ? S_RD_SIZE : S_DONE;
      S_RD_SIZE: if (second) state_nx = S_DECODE;
      S_DECODE:  state_nx = S_WRITE;
      S_WRITE:   state_nx = S_GAP;
      S_GAP:     state_nx = (board_count == LAST_BOARD) ? S_DONE : S_RD_TYPE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Slave port mux: CPU pass-through when idle, internal cycles otherwise.
  // Reset forces everything low so the slave sees nothing while held.
  always_comb begin
    ac_address = 8'h00;
    ac_wdata   = 16'h0000;
    ac_rd      = 1'b0;
    ac_hwr     = 1'b0;
    ac_lwr     = 1'b0;
    ac_sel     = 1'b0;
    cpu_wait   = 1'b0;
    if (!reset) begin
      if (state == S_IDLE) begin
        ac_address = cpu_address;
        ac_wdata   = cpu_data;
        ac_rd      = cpu_rd;
        ac_hwr     = cpu_hwr;
        ac_lwr     = cpu_lwr;
        ac_sel     = cpu_sel;
      end else begin
        cpu_wait = cpu_sel;
        case (state)
          S_RD_TYPE: begin
            ac_address = word_addr(AC_TYPE);
            ac_sel     = 1'b1;
            ac_rd      = 1'b1;
          end
          S_RD_SIZE: begin
            ac_address = word_addr(AC_SIZE);
            ac_sel     = 1'b1;
            ac_rd      = 1'b1;
          end
          S_WRITE: begin
            ac_address = wr_addr;
            ac_wdata   = wr_data;
            ac_sel     = 1'b1;
            ac_hwr     = 1'b1;
            ac_lwr     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath: start latch, captured nibbles, pointers and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      second      <= 1'b0;
      start_pend  <= 1'b0;
      is_z3       <= 1'b0;
      code        <= 3'd0;
      wr_addr     <= 8'h00;
      wr_data     <= 16'h0000;
      board_count <= 3'd0;
      z2_next     <= Z2_START;
      z3_next     <= Z3_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // Start is caught between beats; it is ignored while sequencing
      if (start && !busy) start_pend <= 1'b1;
      if (clk7_en) begin
        case (state)
          S_IDLE: if (go) begin
            start_pend  <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            board_count <= 3'd0;
          end
          S_RD_TYPE: begin
            second <= !second;
            if (second) begin
              is_z3 <= (ac_rdata[15:14] == TYPE_Z3);
              if (!type_ok) busy <= 1'b0;
            end
          end
          S_RD_SIZE: begin
            second <= !second;
            if (second) code <= ac_rdata[14:12];
          end
          S_DECODE: begin
            if (dec_fits) begin
              if (is_z3) begin
                wr_addr <= word_addr(AC_Z3BASE);
                wr_data <= dec_base;
                z3_next <= dec_next;
              end else begin
                wr_addr <= word_addr(AC_Z2BASE);
                wr_data <= {dec_base[7:0], dec_base[7:0]};
                z2_next <= dec_next[7:0];
              end
            end else begin
              wr_addr <= word_addr(AC_SHUTUP);
              wr_data <= 16'h0000;
              error   <= 1'b1;
            end
          end
          S_GAP: begin
            board_count <= board_count + 3'd1;
            if (board_count == LAST_BOARD) begin
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_DONE: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_minimig_autoconfig_sequencer.sv
// Directed bench: behavioural autoconfig slave chain plus hand-computed checks.
module tb_minimig_autoconfig_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cpu_address = 8'h00;
  logic [15:0] cpu_data = 16'h0000;
  logic        cpu_rd = 1'b0, cpu_hwr = 1'b0, cpu_lwr = 1'b0, cpu_sel = 1'b0;
  logic        cpu_wait;
  logic [7:0]  ac_address;
  logic [15:0] ac_wdata;
  logic        ac_rd, ac_hwr, ac_lwr, ac_sel;
  logic [15:0] ac_rdata;
  logic        busy, done, error;
  logic [2:0]  board_count;
  logic [7:0]  z2_next;
  logic [15:0] z3_next;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  minimig_autoconfig_sequencer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .start(start),
    .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_rd(cpu_rd), .cpu_hwr(cpu_hwr), .cpu_lwr(cpu_lwr), .cpu_sel(cpu_sel),
    .cpu_wait(cpu_wait), .ac_address(ac_address), .ac_wdata(ac_wdata),
    .ac_rd(ac_rd), .ac_hwr(ac_hwr), .ac_lwr(ac_lwr), .ac_sel(ac_sel),
    .ac_rdata(ac_rdata), .busy(busy), .done(done), .error(error),
    .board_count(board_count), .z2_next(z2_next), .z3_next(z3_next)
  );

  // Slave model: chain of boards, synchronous ROM, pointer advances on
  // base or shut-up writes. Every full-word write is logged.
  logic [1:0]  brd_type [8];
  logic [2:0]  brd_code [8];
  int          n_brd = 0;
  int          idx;
  logic [7:0]  wl_addr [16];
  logic [15:0] wl_data [16];
  int          wl_n;
  logic        mdl_clr = 1'b1;
  logic [15:0] rdata = 16'h0000;

  assign ac_rdata = rdata;

  always @(posedge clk) begin
    if (mdl_clr) begin
      idx  <= 0;
      wl_n <= 0;
    end else if (clk7_en && ac_sel && ac_hwr && ac_lwr) begin
      wl_addr[wl_n[3:0]] <= ac_address;
      wl_data[wl_n[3:0]] <= ac_wdata;
      wl_n <= wl_n + 1;
      if (ac_address == 8'h22 || ac_address == 8'h24 || ac_address == 8'h26) idx <= idx + 1;
    end
    if (idx < n_brd && ac_address == 8'h00)      rdata <= {brd_type[idx[2:0]], 14'h0};
    else if (idx < n_brd && ac_address == 8'h01) rdata <= {1'b0, brd_code[idx[2:0]], 12'h0};
    else                                         rdata <= 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    mdl_clr = 1'b1;
    cpu_sel = 1'b0; cpu_rd = 1'b0; cpu_hwr = 1'b0; cpu_lwr = 1'b0;
    start   = 1'b0; clk7_en = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    mdl_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_brd(input int i, input logic [1:0] t, input logic [2:0] c);
    brd_type[i] = t;
    brd_code[i] = c;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Run until done, bounded; returns beats counted
  task automatic run(input int max, output int beats);
    beats = 0;
    while (!done && beats < max) begin
      @(posedge clk);
      if (clk7_en) beats++;
      @(negedge clk);
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int b;
    // Reset values, with the CPU holding sel to show the slave is isolated
    reset = 1'b1;
    cpu_sel = 1'b1;
    cpu_rd  = 1'b1;
    #12;
    chk("rst_ac_sel", {31'd0, ac_sel}, 32'd0);
    chk("rst_ac_rd", {31'd0, ac_rd}, 32'd0);
    chk("rst_wait", {31'd0, cpu_wait}, 32'd0);
    chk("rst_status", {29'd0, busy, done, error}, 32'd0);
    chk("rst_count", {29'd0, board_count}, 32'd0);
    chk("rst_z2", {24'd0, z2_next}, 32'h20);
    chk("rst_z3", {16'd0, z3_next}, 32'h4000);

    // 1: Z2 4M then null; start caught while clk7_en is low
    set_brd(0, 2'b11, 3'd7);
    n_brd = 1;
    do_reset();
    @(negedge clk) begin start = 1'b1; clk7_en = 1'b0; end
    @(negedge clk) start = 1'b0;
    chk("t1_not_busy_yet", {31'd0, busy}, 32'd0);
    clk7_en = 1'b1;
    run(40, b);
    chk("t1_beats", b, 32'd11);
    chk("t1_wr_n", wl_n, 32'd1);
    chk("t1_wr_addr", {24'd0, wl_addr[0]}, 32'h24);
    chk("t1_wr_data", {16'd0, wl_data[0]}, 32'h2020);
    chk("t1_z2", {24'd0, z2_next}, 32'h60);
    chk("t1_count", {29'd0, board_count}, 32'd1);
    chk("t1_err_busy", {30'd0, error, busy}, 32'd0);

    // 2 + CPU isolation: Z2 2M, Z3 64M, null
    set_brd(0, 2'b11, 3'd6);
    set_brd(1, 2'b10, 3'd2);
    n_brd = 2;
    do_reset();
    pulse_start();               // beat 1 on this edge
    @(negedge clk);              // after beat 2, still reading type
    cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_address = 8'h55;
    #1;
    chk("t4_wait", {31'd0, cpu_wait}, 32'd1);
    chk("t4_int_addr", {24'd0, ac_address}, 32'h00);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);   // after beat 7: GAP
    chk("t4_gap_sel", {30'd0, ac_sel, ac_rd}, 32'd0);
    chk("t4_gap_wait", {31'd0, cpu_wait}, 32'd1);
    start = 1'b1;                // ignored while busy
    @(negedge clk) start = 1'b0;
    run(60, b);
    chk("t2_wr_n", wl_n, 32'd2);
    chk("t2_wr0", {wl_addr[0], 8'd0, wl_data[0]}, {8'h24, 8'd0, 16'h2020});
    chk("t2_wr1", {wl_addr[1], 8'd0, wl_data[1]}, {8'h22, 8'd0, 16'h4000});
    chk("t2_z2", {24'd0, z2_next}, 32'h40);
    chk("t2_z3", {16'd0, z3_next}, 32'h4400);
    chk("t2_count_err", {28'd0, board_count, error}, {28'd0, 3'd2, 1'b0});
    cpu_address = 8'h00;
    #1;
    chk("t4_pass_sel_rd", {30'd0, ac_sel, ac_rd}, 32'd3);
    chk("t4_pass_addr", {24'd0, ac_address}, 32'h00);
    chk("t4_pass_wait", {31'd0, cpu_wait}, 32'd0);
    cpu_sel = 1'b0; cpu_rd = 1'b0;

    // 3: fill to 0x90, then a 4M board aligns to 0xA0 and is shut up
    set_brd(0, 2'b11, 3'd7);
    set_brd(1, 2'b11, 3'd6);
    set_brd(2, 2'b11, 3'd5);
    set_brd(3, 2'b11, 3'd7);
    n_brd = 4;
    do_reset();
    pulse_start();
    run(80, b);
    chk("t3_wr_n", wl_n, 32'd4);
    chk("t3_wr2", {wl_addr[2], 8'd0, wl_data[2]}, {8'h24, 8'd0, 16'h8080});
    chk("t3_shutup", {wl_addr[3], 8'd0, wl_data[3]}, {8'h26, 8'd0, 16'h0000});
    chk("t3_z2", {24'd0, z2_next}, 32'h90);
    chk("t3_err", {31'd0, error}, 32'd1);
    chk("t3_count", {29'd0, board_count}, 32'd4);

    // 5: reset during WRITE of a Z2 4M board
    set_brd(0, 2'b11, 3'd7);
    n_brd = 1;
    do_reset();
    pulse_start();
    repeat (5) @(negedge clk);   // after beat 6: WRITE
    chk("t5_write_strb", {30'd0, ac_sel, ac_hwr}, 32'd3);
    chk("t5_write_bus", {ac_address, 8'd0, ac_wdata}, {8'h24, 8'd0, 16'h2020});
    chk("t5_z2_adv", {24'd0, z2_next}, 32'h60);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_strb", {30'd0, ac_sel, ac_hwr}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ptrs", {z2_next, z3_next}, {8'h20, 16'h4000});

    // 6: six Z2 64K boards, MAX_BOARDS=5
    for (int i = 0; i < 6; i++) set_brd(i, 2'b11, 3'd1);
    n_brd = 6;
    do_reset();
    pulse_start();
    run(120, b);
    chk("t6_wr_n", wl_n, 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = 8'h20 + 8'(i);
      chk($sformatf("t6_wr%0d", i), {wl_addr[i], 8'd0, wl_data[i]}, {8'h24, 8'd0, e, e});
    end
    chk("t6_flags", {29'd0, error, done, busy}, {29'd0, 3'b110});
    chk("t6_count", {29'd0, board_count}, 32'd5);
    chk("t6_z2", {24'd0, z2_next}, 32'h25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
